// File: rtl/peres_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peres_pkg
// Description : Shared types and default sizes for the pipelined bitwise
//               Peres gate (peres_pipe). Provides the gate-direction enum and
//               the default vector / counter widths used by the top level.
// Config      : the gate direction is only honoured when PERES_INVERSE_EN is
//               defined (see peres_pipe).
// Revision    : 1.0 - initial release
// ============================================================================
package peres_pkg;

    // Gate direction carried alongside every triple through the pipe.
    typedef enum logic {
        PERES_FWD = 1'b0,
        PERES_INV = 1'b1
    } peres_mode_e;

    // Default width of each of the a/b/c (and p/q/r) vectors.
    localparam int PERES_WIDTH_DEFAULT = 8;

    // Default width of the completed-output-transfer counter.
    localparam int PERES_CNT_W_DEFAULT = 16;

endpackage : peres_pkg
`default_nettype wire

// File: rtl/peres_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : peres_pipe_stage
// Description : One elastic pipeline slot: a valid bit plus a data word that
//               are both loaded together whenever the stage is allowed to
//               advance. When advance is low the slot holds its contents, which
//               is what keeps downstream outputs stable under backpressure.
// Ports       : clk       - rising-edge clock
//               rst_n     - synchronous active-low reset, clears valid and data
//               advance   - load enable for this slot
//               valid_in  - valid bit offered by the upstream side
//               data_in   - data word offered by the upstream side
//               valid_out - registered valid bit
//               data_out  - registered data word
// Revision    : 1.0 - initial release
// ============================================================================
module peres_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Data is loaded even when valid_in is low: a bubble carries don't-care
    // data, and skipping the data enable keeps the slot a plain register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (advance) begin
            valid_q <= valid_in;
            data_q  <= data_in;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;

endmodule : peres_pipe_stage
`default_nettype wire

// File: rtl/peres_pipe.sv
`default_nettype none
// ============================================================================
// Module      : peres_pipe
// Description : Two-stage valid/ready pipeline computing a bitwise Peres gate
//               on WIDTH-bit lanes.
//                 forward : p = a, q = a ^ b, r = (a &  b) ^ c
//                 inverse : p = a, q = a ^ b, r = (a & ~b) ^ c
//               S1 registers a, a^b, c, the mode and the AND partial term;
//               S2 registers the finished p/q/r and mode, which drive the
//               outputs directly. Full throughput with a combinational ready
//               chain; holds two triples when the output is stalled.
// Config      : PERES_INVERSE_EN defined   -> mode selects forward/inverse.
//               PERES_INVERSE_EN undefined -> mode ignored, always forward,
//                                             out_mode constant 0.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               in_valid / in_ready   - input handshake
//               a, b, c, mode         - input triple and gate direction
//               out_valid / out_ready - output handshake
//               p, q, r, out_mode     - result triple and its direction
//               xfer_cnt              - wrapping count of output transfers
// Revision    : 1.0 - initial release
// ============================================================================
module peres_pipe
    import peres_pkg::*;
#(
    parameter int WIDTH = PERES_WIDTH_DEFAULT,
    parameter int CNT_W = PERES_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             out_mode,
    output logic [CNT_W-1:0] xfer_cnt
);

    // ------------------------------------------------------------------
    // Stage payloads
    // ------------------------------------------------------------------
    typedef struct packed {
        peres_mode_e      mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] axb;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] partial;
    } s1_t;

    typedef struct packed {
        peres_mode_e      mode;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
    } s2_t;

    localparam int S1_W = $bits(s1_t);
    localparam int S2_W = $bits(s2_t);

    // ------------------------------------------------------------------
    // Effective gate direction
    // ------------------------------------------------------------------
    peres_mode_e in_mode;

`ifdef PERES_INVERSE_EN
    assign in_mode = peres_mode_e'(mode);
`else
    // Direction is fixed to forward; the port stays for interface
    // compatibility and is deliberately left without a load.
    logic unused_mode;
    assign unused_mode = mode;
    assign in_mode     = PERES_FWD;
`endif

    // ------------------------------------------------------------------
    // Handshake / advance chain
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;
    logic in_fire;
    logic out_fire;

    // A stage may load when it is empty or when its contents move on this
    // cycle. The chain is combinational from out_ready back to in_ready,
    // which is what gives full throughput with only two slots.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = rst_n && s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid && out_ready;

    // ------------------------------------------------------------------
    // S1: split the gate so only one XOR sits after the S1 register
    // ------------------------------------------------------------------
    s1_t             s1_d;
    s1_t             s1_q;
    logic [S1_W-1:0] s1_q_bits;

    always_comb begin
        s1_d.mode    = in_mode;
        s1_d.a       = a;
        s1_d.axb     = a ^ b;
        s1_d.c       = c;
        s1_d.partial = (in_mode == PERES_INV) ? (a & ~b) : (a & b);
    end

    peres_pipe_stage #(
        .DATA_W (S1_W)
    ) u_stage_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (s1_adv),
        .valid_in  (in_fire),
        .data_in   (s1_d),
        .valid_out (s1_valid),
        .data_out  (s1_q_bits)
    );

    assign s1_q = s1_t'(s1_q_bits);

    // ------------------------------------------------------------------
    // S2: finish r and present the result straight from registers
    // ------------------------------------------------------------------
    s2_t             s2_d;
    s2_t             s2_q;
    logic [S2_W-1:0] s2_q_bits;

    always_comb begin
        s2_d.mode = s1_q.mode;
        s2_d.p    = s1_q.a;
        s2_d.q    = s1_q.axb;
        s2_d.r    = s1_q.c ^ s1_q.partial;
    end

    peres_pipe_stage #(
        .DATA_W (S2_W)
    ) u_stage_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (s2_adv),
        .valid_in  (s1_valid),
        .data_in   (s2_d),
        .valid_out (s2_valid),
        .data_out  (s2_q_bits)
    );

    assign s2_q = s2_t'(s2_q_bits);

    assign out_valid = s2_valid;
    assign p         = s2_q.p;
    assign q         = s2_q.q;
    assign r         = s2_q.r;
    assign out_mode  = s2_q.mode;

    // ------------------------------------------------------------------
    // Output transfer counter (wraps naturally at 2^CNT_W)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (out_fire) begin
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
        end
    end

    assign xfer_cnt = xfer_cnt_q;

endmodule : peres_pipe
`default_nettype wire

// File: tb/tb_peres_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_peres_pipe
// Description : Self-checking bench for peres_pipe (WIDTH=8, CNT_W=4).
//               Table vectors and generated traffic push expected results
//               into a scoreboard at input acceptance; a negedge monitor pops
//               and compares at every output transfer. Hand sequences cover
//               reset, stage timing, backpressure, wrap and mid-flight reset.
// Config      : expectations follow PERES_INVERSE_EN the same way the DUT does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peres_pipe;
    import peres_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef PERES_INVERSE_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, c;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  p, q, r;
    logic          out_mode;
    logic [CW-1:0] xfer_cnt;

    always #5 clk = ~clk;

    peres_pipe #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .q         (q),
        .r         (r),
        .out_mode  (out_mode),
        .xfer_cnt  (xfer_cnt)
    );

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] r;
        logic       m;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       m;
        res_t       e_inv;   // expectation when the inverse gate is enabled
        res_t       e_fwd;   // expectation when only forward exists
    } vec_t;

    res_t sb[$];
    res_t cur_exp;
    res_t got;
    res_t exp_pop;
    res_t snap;
    int   errors   = 0;
    int   checks   = 0;
    int   accepted = 0;
    int   xfers    = 0;
    bit   rand_bp  = 1'b0;

    function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic [7:0] mc, input logic mm);
        res_t  e;
        logic  inv;
        inv  = INV_EN & mm;
        e.p  = ma;
        e.q  = ma ^ mb;
        e.r  = inv ? ((ma & ~mb) ^ mc) : ((ma & mb) ^ mc);
        e.m  = inv;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop before push, since a triple accepted this edge cannot be
    // the one leaving this edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got = {p, q, r, out_mode};
            xfers++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: actual=%0h required=none", got);
            end else begin
                exp_pop = sb.pop_front();
                if (got !== exp_pop) begin
                    errors++;
                    $display("FAIL sb_result: actual=%0h required=%0h", got, exp_pop);
                end
            end
        end
        if (rst_n && in_valid && in_ready) begin
            sb.push_back(cur_exp);
            accepted++;
        end
    end

    // Offer one triple and return just after the edge that accepts it.
    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                        input logic vm, input res_t e);
        int n;
        bit done;
        a = va; b = vb; c = vc; mode = vm; cur_exp = e; in_valid = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    check("send_timeout", 32'(in_ready), 32'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_model(input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] vc, input logic vm);
        send(va, vb, vc, vm, model(va, vb, vc, vm));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        xfers = 0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];

    initial begin
        int acc0;
        int x0;
        int bad;

        vecs[0] = '{8'hF0, 8'hCC, 8'hAA, 1'b0, {8'hF0, 8'h3C, 8'h6A, 1'b0}, {8'hF0, 8'h3C, 8'h6A, 1'b0}};
        vecs[1] = '{8'hF0, 8'h3C, 8'h6A, 1'b1, {8'hF0, 8'hCC, 8'hAA, 1'b1}, {8'hF0, 8'hCC, 8'h5A, 1'b0}};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, {8'hFF, 8'h00, 8'hFF, 1'b0}, {8'hFF, 8'h00, 8'hFF, 1'b0}};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, {8'h00, 8'h00, 8'h00, 1'b0}, {8'h00, 8'h00, 8'h00, 1'b0}};
        vecs[4] = '{8'h55, 8'hAA, 8'h0F, 1'b1, {8'h55, 8'hFF, 8'h5A, 1'b1}, {8'h55, 8'hFF, 8'h0F, 1'b0}};
        vecs[5] = '{8'hA5, 8'h3C, 8'hFF, 1'b0, {8'hA5, 8'h99, 8'hDB, 1'b0}, {8'hA5, 8'h99, 8'hDB, 1'b0}};
        vecs[6] = '{8'h0F, 8'hF0, 8'h33, 1'b1, {8'h0F, 8'hFF, 8'h3C, 1'b1}, {8'h0F, 8'hFF, 8'h33, 1'b0}};
        vecs[7] = '{8'hF0, 8'hCC, 8'hAA, 1'b1, {8'hF0, 8'h3C, 8'h9A, 1'b1}, {8'hF0, 8'h3C, 8'h6A, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; mode = 1'b0; cur_exp = '0;
        do_reset();

        // ---- table vectors, back-to-back, no stall ----
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].m,
                 INV_EN ? vecs[i].e_inv : vecs[i].e_fwd);
        end
        in_valid = 1'b0;
        drain();

        // ---- stage timing: S1 after the capture edge, S2 one edge later ----
        send_model(8'hF0, 8'hCC, 8'hAA, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_after_s1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_after_s2", 32'(out_valid), 32'd1);
        check("lat_r", 32'(r), 32'h6A);
        @(posedge clk); #1;
        drain();

        // ---- backpressure: two held, third blocked, then three in a row ----
        out_ready = 1'b0;
        acc0 = accepted;
        send_model(8'h11, 8'h22, 8'h33, 1'b0);
        send_model(8'h44, 8'h55, 8'h66, 1'b1);
        a = 8'h77; b = 8'h88; c = 8'h99; mode = 1'b0;
        cur_exp = model(8'h77, 8'h88, 8'h99, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) snap = {p, q, r, out_mode};
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        check("bp_stable", 32'({p, q, r, out_mode}), 32'(snap));
        check("bp_accepted", 32'(accepted - acc0), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!out_valid) bad++;
            @(posedge clk); #1;
            if (i == 0) in_valid = 1'b0;
        end
        check("bp_back_to_back", 32'(bad), 32'd0);
        drain();
        check("bp_accepted_all", 32'(accepted - acc0), 32'd3);

        // ---- generated traffic under random output stalls ----
        rand_bp = 1'b1;
        fork
            begin
                while (rand_bp) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 40; i++) begin
            send_model(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check("cnt_tracks_xfers", 32'(xfer_cnt), 32'(4'(xfers)));

        // ---- reset with two triples in flight ----
        out_ready = 1'b0;
        send_model(8'hDE, 8'hAD, 8'hBE, 1'b0);
        send_model(8'hEF, 8'h01, 8'h23, 1'b1);
        in_valid = 1'b0;
        x0 = xfers;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("midrst_no_output", 32'(bad), 32'd0);
        check("midrst_no_xfer", 32'(xfers - x0), 32'd0);
        @(posedge clk); #1;

        // ---- counter wrap: 17 transfers from reset leave 1 ----
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_model(8'(i * 13), 8'(i * 7 + 1), 8'(255 - i), 1'(i & 1));
        end
        in_valid = 1'b0;
        drain();
        check("wrap_xfers", 32'(xfers), 32'd17);
        check("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_peres_pipe
`default_nettype wire
